// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam int S_IF  = 0;
  localparam int S_ID  = 1;
  localparam int S_EX  = 2;
  localparam int S_MEM = 3;
  localparam int S_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// EX-stage operand forwarding comparator; the MEM result wins over the WB result.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wr,
  output fwd_sel_e              sel
);

  // Priority select of the youngest matching producer
  always_comb begin
    sel = FWD_RF;
    if (mem_wr && (mem_rd == src_rs) && (mem_rd != {REG_ADDR_W{1'b0}})) begin
      sel = FWD_MEM;
    end else if (wb_wr && (wb_rd == src_rs) && (wb_rd != {REG_ADDR_W{1'b0}})) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32 core.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int BR_STAGE   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_is_branch,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [4:0]            stage_valid,
  output logic                  mem_wait
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_events,
  output logic [31:0]           perf_mem_wait_cycles
`endif
);

  localparam logic [0:0] ST_RUN      = RUN;
  localparam logic [0:0] ST_MEM_WAIT = MEM_WAIT;

  if ((BR_STAGE != 1) && (BR_STAGE != 2)) begin : g_bad_br_stage
    $error("pipe_hazard_ctrl: BR_STAGE must be 1 (ID) or 2 (EX)");
  end

  logic [4:0] valid_r;
  logic [0:0] state_r;
  logic       mem_load_r;

  logic pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s;
  logic if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mem_wb_flush_s;
  logic freeze_s, redirect_s, load_use_s, br_hz_s;
  logic stall_take_s, redirect_take_s;
  fwd_sel_e fwd_a_s, fwd_b_s;

  // Non-zero rd read by the instruction currently in ID
  function automatic logic id_reads(input logic [REG_ADDR_W-1:0] rd);
    return (rd != {REG_ADDR_W{1'b0}}) &&
           ((id_uses_rs1 && (id_rs1 == rd)) || (id_uses_rs2 && (id_rs2 == rd)));
  endfunction

  assign freeze_s   = mem_req & valid_r[S_MEM] & ~mem_ready;
  assign redirect_s = redirect & ((BR_STAGE == 1) ? valid_r[S_ID] : valid_r[S_EX]);
  assign load_use_s = valid_r[S_ID] & valid_r[S_EX] & ex_mem_read & id_reads(ex_rd);
  assign br_hz_s    = (BR_STAGE == 1) & valid_r[S_ID] & id_is_branch &
                      ((valid_r[S_EX] & ex_reg_write & id_reads(ex_rd)) |
                       (valid_r[S_MEM] & mem_load_r & id_reads(mem_rd)));

  // Prioritised enable/flush decision
  always_comb begin
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    id_ex_en_s      = 1'b1;
    ex_mem_en_s     = 1'b1;
    mem_wb_en_s     = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_flush_s  = 1'b0;
    mem_wb_flush_s  = 1'b0;
    stall_take_s    = 1'b0;
    redirect_take_s = 1'b0;
    if (freeze_s) begin
      pc_en_s        = 1'b0;
      if_id_en_s     = 1'b0;
      id_ex_en_s     = 1'b0;
      ex_mem_en_s    = 1'b0;
      mem_wb_flush_s = 1'b1;
    end else if (redirect_s) begin
      redirect_take_s = 1'b1;
      if_id_flush_s   = 1'b1;
      id_ex_flush_s   = (BR_STAGE == 2);
    end else if (load_use_s || br_hz_s) begin
      stall_take_s  = 1'b1;
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      id_ex_flush_s = 1'b1;
    end else begin
      stall_take_s  = 1'b0;
    end
  end

  // Reset overrides every control output combinationally
  always_comb begin
    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
      fwd_a = 2'd0;
      fwd_b = 2'd0;
    end else begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} =
        {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s};
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} =
        {if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mem_wb_flush_s};
      fwd_a = fwd_a_s;
      fwd_b = fwd_b_s;
    end
  end

  assign stage_valid = valid_r;
  assign mem_wait    = (state_r == ST_MEM_WAIT);

  // Valid bits follow the pipeline registers they shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r    <= 5'b00000;
      mem_load_r <= 1'b0;
    end else begin
      if (pc_en_s)     valid_r[S_IF]  <= 1'b1;
      if (if_id_en_s)  valid_r[S_ID]  <= ~if_id_flush_s  & valid_r[S_IF];
      if (id_ex_en_s)  valid_r[S_EX]  <= ~id_ex_flush_s  & valid_r[S_ID];
      if (ex_mem_en_s) valid_r[S_MEM] <= ~ex_mem_flush_s & valid_r[S_EX];
      if (mem_wb_en_s) valid_r[S_WB]  <= ~mem_wb_flush_s & valid_r[S_MEM];
      // MEM-stage load flag feeds the ID-branch operand check
      if (ex_mem_en_s) mem_load_r <= ~ex_mem_flush_s & valid_r[S_EX] & ex_mem_read;
    end
  end

  // Memory-wait status FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:      if (freeze_s)  state_r <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ready) state_r <= ST_RUN;
        default:     state_r <= ST_RUN;
      endcase
    end
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src_rs (ex_rs1),
    .mem_rd (mem_rd),
    .mem_wr (valid_r[S_MEM] & mem_reg_write),
    .wb_rd  (wb_rd),
    .wb_wr  (valid_r[S_WB] & wb_reg_write),
    .sel    (fwd_a_s)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src_rs (ex_rs2),
    .mem_rd (mem_rd),
    .mem_wr (valid_r[S_MEM] & mem_reg_write),
    .wb_rd  (wb_rd),
    .wb_wr  (valid_r[S_WB] & wb_reg_write),
    .sel    (fwd_b_s)
  );

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_r, flush_cnt_r, wait_cnt_r;

  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
      wait_cnt_r  <= 32'd0;
    end else begin
      if (stall_take_s && (stall_cnt_r != 32'hFFFF_FFFF))    stall_cnt_r <= stall_cnt_r + 32'd1;
      if (redirect_take_s && (flush_cnt_r != 32'hFFFF_FFFF)) flush_cnt_r <= flush_cnt_r + 32'd1;
      if (freeze_s && (wait_cnt_r != 32'hFFFF_FFFF))         wait_cnt_r  <= wait_cnt_r + 32'd1;
    end
  end

  assign perf_stall_cycles    = stall_cnt_r;
  assign perf_flush_events    = flush_cnt_r;
  assign perf_mem_wait_cycles = wait_cnt_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = stall_take_s ^ redirect_take_s;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with EX-stage and one with ID-stage redirects.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, id_is_branch, ex_reg_write, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, redirect, mem_req, mem_ready;

  logic [8:0] ctrl_ex, ctrl_id;
  logic [1:0] fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id;
  logic [4:0] valid_ex, valid_id;
  logic       wait_ex, wait_id;

  int checks = 0;
  int errors = 0;

  // ctrl = {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes}
  localparam logic [8:0] C_NORM   = 9'b11111_0000;
  localparam logic [8:0] C_RESET  = 9'b00000_1111;
  localparam logic [8:0] C_STALL  = 9'b00111_0100;
  localparam logic [8:0] C_RD_EX  = 9'b11111_1100;
  localparam logic [8:0] C_RD_ID  = 9'b11111_1000;
  localparam logic [8:0] C_FREEZE = 9'b00001_0001;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .BR_STAGE(2)) u_ex (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_is_branch(id_is_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(ctrl_ex[8]), .if_id_en(ctrl_ex[7]), .id_ex_en(ctrl_ex[6]), .ex_mem_en(ctrl_ex[5]),
    .mem_wb_en(ctrl_ex[4]), .if_id_flush(ctrl_ex[3]), .id_ex_flush(ctrl_ex[2]),
    .ex_mem_flush(ctrl_ex[1]), .mem_wb_flush(ctrl_ex[0]),
    .fwd_a(fwd_a_ex), .fwd_b(fwd_b_ex), .stage_valid(valid_ex), .mem_wait(wait_ex)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .BR_STAGE(1)) u_id (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_is_branch(id_is_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(ctrl_id[8]), .if_id_en(ctrl_id[7]), .id_ex_en(ctrl_id[6]), .ex_mem_en(ctrl_id[5]),
    .mem_wb_en(ctrl_id[4]), .if_id_flush(ctrl_id[3]), .id_ex_flush(ctrl_id[2]),
    .ex_mem_flush(ctrl_id[1]), .mem_wb_flush(ctrl_id[0]),
    .fwd_a(fwd_a_id), .fwd_b(fwd_b_id), .stage_valid(valid_id), .mem_wait(wait_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = {7{5'd0}};
    {id_uses_rs1, id_uses_rs2, id_is_branch, ex_reg_write, ex_mem_read} = 5'b00000;
    {mem_reg_write, wb_reg_write, redirect, mem_req} = 4'b0000;
    mem_ready = 1'b1;
  endtask

  // Reset both instances, then run 5 idle cycles so every stage is valid
  task automatic reset_and_fill();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    reset_and_fill();
    checks++;
    if (valid_ex !== 5'b11111) begin errors++; $display("FAIL fill_valid: got %b want %b", valid_ex, 5'b11111); end
    set_load_use();
    #1;
    checks++;
    if (ctrl_ex !== C_STALL) begin errors++; $display("FAIL pre_reset_stall: got %b want %b", ctrl_ex, C_STALL); end
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl_ex !== C_RESET) begin errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl_ex, C_RESET); end
    checks++;
    if ({valid_ex, fwd_a_ex, fwd_b_ex, wait_ex} !== 10'd0) begin
      errors++; $display("FAIL reset_state: valid=%b fwd=%0d/%0d wait=%b want all 0", valid_ex, fwd_a_ex, fwd_b_ex, wait_ex);
    end
    tick();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] exp_v;
      tick();
      exp_v = 5'((32'd1 << (i + 1)) - 32'd1);
      checks++;
      if (valid_ex !== exp_v) begin errors++; $display("FAIL ramp_%0d: got %b want %b", i, valid_ex, exp_v); end
    end
  endtask

  task automatic test_load_use();
    reset_and_fill();
    set_load_use();
    #1;
    checks++;
    if (ctrl_ex !== C_STALL) begin errors++; $display("FAIL lu_stall: got %b want %b", ctrl_ex, C_STALL); end
    tick();
    checks++;
    if (ctrl_ex !== C_NORM) begin errors++; $display("FAIL lu_one_cycle: got %b want %b", ctrl_ex, C_NORM); end
    checks++;
    if (valid_ex !== 5'b11011) begin errors++; $display("FAIL lu_bubble: got %b want %b", valid_ex, 5'b11011); end
    reset_and_fill();
    set_load_use();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    checks++;
    if (ctrl_ex !== C_NORM) begin errors++; $display("FAIL lu_x0: got %b want %b", ctrl_ex, C_NORM); end
  endtask

  task automatic test_redirect();
    reset_and_fill();
    set_load_use();
    redirect = 1'b1;
    #1;
    checks++;
    if (ctrl_ex !== C_RD_EX) begin errors++; $display("FAIL redir_ex: got %b want %b", ctrl_ex, C_RD_EX); end
    checks++;
    if (ctrl_id !== C_RD_ID) begin errors++; $display("FAIL redir_id: got %b want %b", ctrl_id, C_RD_ID); end
    tick();
    checks++;
    if (valid_ex !== 5'b11001) begin errors++; $display("FAIL redir_valid: got %b want %b", valid_ex, 5'b11001); end
  endtask

  task automatic test_mem_wait();
    reset_and_fill();
    mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ctrl_ex !== C_FREEZE || wait_ex !== (c != 0)) begin
        errors++; $display("FAIL freeze_%0d: ctrl=%b wait=%b want ctrl=%b wait=%b", c, ctrl_ex, wait_ex, C_FREEZE, c != 0);
      end
      tick();
    end
    checks++;
    if (valid_ex !== 5'b01111) begin errors++; $display("FAIL freeze_valid: got %b want %b", valid_ex, 5'b01111); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl_ex !== C_RD_EX || wait_ex !== 1'b1) begin
      errors++; $display("FAIL release: ctrl=%b wait=%b want ctrl=%b wait=1", ctrl_ex, wait_ex, C_RD_EX);
    end
    tick();
    checks++;
    if (wait_ex !== 1'b0) begin errors++; $display("FAIL wait_exit: got %b want 0", wait_ex); end
  endtask

  task automatic test_forwarding();
    reset_and_fill();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    #1;
    checks++;
    if (fwd_a_ex !== 2'd2 || fwd_b_ex !== 2'd2) begin errors++; $display("FAIL fwd_mem: got %0d/%0d want 2/2", fwd_a_ex, fwd_b_ex); end
    mem_reg_write = 1'b0;
    #1;
    checks++;
    if (fwd_a_ex !== 2'd1) begin errors++; $display("FAIL fwd_mem_nowr: got %0d want 1", fwd_a_ex); end
    mem_reg_write = 1'b1;
    set_load_use();
    tick();
    ex_mem_read = 1'b0;
    tick();
    checks++;
    if (valid_ex !== 5'b10111) begin errors++; $display("FAIL fwd_setup: got %b want %b", valid_ex, 5'b10111); end
    checks++;
    if (fwd_a_ex !== 2'd1) begin errors++; $display("FAIL fwd_wb: got %0d want 1", fwd_a_ex); end
    wb_rd = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0;
    #1;
    checks++;
    if (fwd_b_ex !== 2'd0) begin errors++; $display("FAIL fwd_x0: got %0d want 0", fwd_b_ex); end
  endtask

  task automatic test_branch_id();
    reset_and_fill();
    id_is_branch = 1'b1; id_uses_rs2 = 1'b1; id_rs2 = 5'd9;
    ex_rd = 5'd9; ex_reg_write = 1'b1;
    #1;
    checks++;
    if (ctrl_id !== C_STALL) begin errors++; $display("FAIL br_alu_stall: got %b want %b", ctrl_id, C_STALL); end
    checks++;
    if (ctrl_ex !== C_NORM) begin errors++; $display("FAIL br_ignored_ex: got %b want %b", ctrl_ex, C_NORM); end
    tick();
    mem_rd = 5'd9; mem_reg_write = 1'b1;
    #1;
    checks++;
    if (ctrl_id !== C_NORM) begin errors++; $display("FAIL br_alu_release: got %b want %b", ctrl_id, C_NORM); end
    reset_and_fill();
    id_is_branch = 1'b1; id_uses_rs2 = 1'b1; id_rs2 = 5'd9;
    ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    #1;
    checks++;
    if (ctrl_id !== C_STALL) begin errors++; $display("FAIL br_load_stall1: got %b want %b", ctrl_id, C_STALL); end
    tick();
    mem_rd = 5'd9; mem_reg_write = 1'b1;
    #1;
    checks++;
    if (ctrl_id !== C_STALL) begin errors++; $display("FAIL br_load_stall2: got %b want %b", ctrl_id, C_STALL); end
    checks++;
    if (ctrl_ex !== C_NORM) begin errors++; $display("FAIL br_load_ex_once: got %b want %b", ctrl_ex, C_NORM); end
    tick();
    checks++;
    if (ctrl_id !== C_NORM) begin errors++; $display("FAIL br_load_release: got %b want %b", ctrl_id, C_NORM); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_forwarding();
    test_branch_id();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Generates per-stage register enables and flushes, EX-stage forwarding selects, and per-stage valid bits.
- Resolves load-use stalls, branch/jump redirects and multi-cycle data-memory waits.
- Supports branch resolution in EX or ID, selected by parameter.

Parameters:
- REG_ADDR_W, 5, register-index width.
- BR_STAGE, 2, stage resolving redirects: 2 = EX, 1 = ID. Any other value is an elaboration error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads the source
- id_is_branch  in  1  ID holds branch/jalr; used only when BR_STAGE=1
- ex_rs1, ex_rs2  in  REG_ADDR_W  EX source registers
- ex_rd  in  REG_ADDR_W  EX destination register
- ex_reg_write, ex_mem_read  in  1  EX writes a register / EX is a load
- mem_rd, wb_rd  in  REG_ADDR_W  MEM / WB destination registers
- mem_reg_write, wb_reg_write  in  1  MEM / WB write a register
- redirect  in  1  taken branch/jump resolved in stage BR_STAGE
- mem_req  in  1  MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble (nop, valid=0)
- fwd_a, fwd_b  out  2  forwarding select: 0 = register file, 1 = WB, 2 = MEM
- stage_valid  out  5  valid bits, [0]=IF … [4]=WB
- mem_wait  out  1  FSM in MEM_WAIT

Behaviour:
- Reset state: all valid bits 0, FSM RUN, if_v = 0.
- While reset is high: every *_en = 0, every *_flush = 1, fwd_a = fwd_b = 0, mem_wait = 0, stage_valid = 0.
- if_v is set to 1 on the first clk edge after reset deasserts.
- Valid pipeline: when a stage's enable is 1, its valid bit loads the previous stage's valid, or 0 if that stage's flush is 1. When the enable is 0, the valid bit holds.
- All outputs are combinational from inputs and registered state; zero latency.
- A hazard condition only counts when the involved stages are valid. Register index 0 never matches.
- FSM states: RUN and MEM_WAIT.
  - RUN → MEM_WAIT when mem_req & v_mem & !mem_ready.
  - MEM_WAIT → RUN in the cycle mem_ready=1.
  - mem_wait = (FSM in MEM_WAIT). It is a status output only; the freeze is driven by the combinational condition below.
- Priority, highest first:
  1. Memory wait: mem_req & v_mem & !mem_ready. pc_en, if_id_en, id_ex_en and ex_mem_en are 0. mem_wb_en = 1 with mem_wb_flush = 1, so a bubble enters WB. A pending redirect is held, because its stage is frozen, and acts on the release cycle.
  2. Redirect from a valid BR_STAGE. pc_en = 1 to load the target. Flush every younger stage: BR_STAGE=2 flushes IF/ID and ID/EX; BR_STAGE=1 flushes IF/ID. A simultaneous load-use or branch-operand hazard in ID is discarded.
  3. Load-use: v_ex & ex_mem_read & ex_rd == a used id_rs. pc_en = 0, if_id_en = 0, id_ex_flush = 1; EX/MEM and MEM/WB advance. Exactly one stall cycle.
  4. Branch-operand hazard, BR_STAGE=1 only: id_is_branch & used id_rs matches ex_rd (ex_reg_write) or mem_rd of a MEM load. Stall as in item 3 until the hazard clears.
  5. Otherwise all enables are 1 and all flushes are 0.
- Forwarding for fwd_a (ex_rs1); fwd_b identical with ex_rs2:
  - 2 if v_mem & mem_reg_write & mem_rd == ex_rs1 & mem_rd != 0.
  - else 1 if v_wb & wb_reg_write & wb_rd match under the same rule.
  - else 0.
  - Value 3 is never driven.
- Reset mid-operation clears all state immediately; no partial transition completes.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds three 32-bit saturating counters as outputs:
  - perf_stall_cycles: incremented on load-use or branch stalls.
  - perf_flush_events: incremented on each redirect.
  - perf_mem_wait_cycles: incremented on each memory-freeze cycle.
  - All three clear on reset.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - enum fwd_sel_e: FWD_RF=0, FWD_WB=1, FWD_MEM=2.
  - enum hz_state_e: RUN, MEM_WAIT.
  - Stage index constants S_IF … S_WB.
- One natural sub-module, fwd_select: the combinational forwarding comparator, instantiated twice (operands A and B).

Test Plan:
- Reset asserted mid-stall (load-use active) → same cycle: all flushes 1, enables 0, stage_valid=0; after release, stage_valid ramps 00001→11111 over 4 cycles.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; normal enables next cycle. Same stimulus with ex_rd=0 → no stall.
- BR_STAGE=2: redirect=1 together with a load-use hazard → pc_en=1, if_id_flush=1, id_ex_flush=1, no stall; stage_valid[2:1] become 0 next cycle.
- mem_req=1, mem_ready low for 3 cycles → 3 cycles with mem_wait=1, front enables 0, mem_wb_flush=1; release on cycle 4; a held redirect acts on that cycle.
- Forwarding priority: mem_rd=wb_rd=7, both writing and valid, ex_rs1=7 → fwd_a=2; MEM invalid → fwd_a=1; wb_rd=0 with ex_rs2=0 → fwd_b=0.
- BR_STAGE=1: id_is_branch=1, id_rs2=9, ex_rd=9, ex_reg_write=1 → one stall cycle. A MEM load to x9 following it → a second stall cycle.
